// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding and default sizes shared by the arbiter and its FIFO
package fifo_arb_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority picker, first set req bit at or above base (wrapping) wins
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(base) + k) % N]) begin
        idx = IW'((int'(base) + k) % N);
        any = 1'b1;
      end
    end
    gnt = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin FIFO write arbiter with credit-tracked occupancy and flush/drain mode
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      rd_en,
  input  logic                      flush,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         wr_data,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty,
  output logic                      flushing
);
  localparam int IW = $clog2(N_REQ);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N_REQ-1:0] gnt;
  logic any, grant_ok, pop;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req(req_valid),
    .base(ptr_q),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  always_comb begin
    full = !rst && count_q == CNT_W'(DEPTH);
    empty = rst || count_q == '0;
    flushing = !rst && state_q == ST_FLUSH;
    count = count_q;
    grant_ok = state_q == ST_RUN && !flush && !full && !rst;
    wr_en = grant_ok && any;
    req_ready = wr_en ? gnt : '0;
    grant_id = wr_en ? idx : '0;
    wr_data = wr_en ? req_data[int'(idx)*DATA_W +: DATA_W] : '0;
    pop = rd_en && count_q != '0;
    count_d = (wr_en && !pop) ? count_q + CNT_W'(1) :
              (pop && !wr_en) ? count_q - CNT_W'(1) : count_q;
    ptr_d = !wr_en ? ptr_q : (int'(idx) == N_REQ - 1) ? '0 : idx + IW'(1);
    state_d = state_q == ST_RUN ? (flush ? ST_FLUSH : ST_RUN)
                                : ((!flush && count_q == '0) ? ST_RUN : ST_FLUSH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized self-checking bench against a behavioural occupancy/round-robin model
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int DW = 4;
  localparam int D = 8;
  localparam int CW = $clog2(D + 1);
  logic clk = 1'b0;
  logic rst, rd_en, flush;
  logic [N-1:0] pv;
  logic [DW-1:0] pd [N];
  logic [N*DW-1:0] req_data;
  logic [N-1:0] req_ready;
  logic wr_en, full, empty, flushing;
  logic [DW-1:0] wr_data;
  logic [$clog2(N)-1:0] grant_id;
  logic [CW-1:0] count;
  int n_chk = 0;
  int n_err = 0;
  int m_cnt, m_ptr;
  bit m_fl;
  always #5 clk = ~clk;
  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pd[i];
  end
  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(pv),
    .req_data(req_data),
    .req_ready(req_ready),
    .rd_en(rd_en),
    .flush(flush),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .grant_id(grant_id),
    .count(count),
    .full(full),
    .empty(empty),
    .flushing(flushing)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int mask, input int p_val, input int p_rd, input int p_fl, input int p_rst);
    int w;
    bit ok;
    rst = $urandom_range(99) < p_rst;
    flush = $urandom_range(99) < p_fl;
    rd_en = $urandom_range(99) < p_rd;
    @(negedge clk);
    ok = !m_fl && !flush && m_cnt < D && !rst;
    w = -1;
    for (int off = 0; off < N; off++)
      if (ok && w < 0 && pv[(m_ptr + off) % N]) w = (m_ptr + off) % N;
    check("req_ready", 32'(req_ready), w >= 0 ? 32'(1) << w : 0);
    check("wr_en", 32'(wr_en), 32'(w >= 0));
    check("wr_data", 32'(wr_data), w >= 0 ? 32'(pd[w]) : 0);
    check("grant_id", 32'(grant_id), w >= 0 ? 32'(w) : 0);
    check("count", 32'(count), 32'(m_cnt));
    check("full", 32'(full), 32'(!rst && m_cnt == D));
    check("empty", 32'(empty), 32'(rst || m_cnt == 0));
    check("flushing", 32'(flushing), 32'(!rst && m_fl));
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_ptr = 0;
      m_fl = 0;
    end else begin
      if (w >= 0) m_ptr = (w + 1) % N;
      if (!m_fl && flush) m_fl = 1;
      else if (m_fl && !flush && m_cnt == 0) m_fl = 0;
      m_cnt = m_cnt + (w >= 0 ? 1 : 0) - ((rd_en && m_cnt > 0) ? 1 : 0);
    end
    #1;
    if (w >= 0) pv[w] = 1'b0;
    if (rst) pv = '0;
    for (int i = 0; i < N; i++)
      if (!pv[i] && mask[i] && $urandom_range(99) < p_val) begin
        pv[i] = 1'b1;
        pd[i] = DW'($urandom);
      end
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    rd_en = 1'b0;
    pv = '1;
    for (int i = 0; i < N; i++) pd[i] = DW'(i + 1);
    @(posedge clk);
    #1;
    m_cnt = 0;
    m_ptr = 0;
    m_fl = 0;
    for (int i = 0; i < 3; i++) step(4'hf, 100, 0, 0, 100);
    for (int i = 0; i < 12; i++) step(4'hf, 100, 100, 0, 0);
    step(4'h1, 100, 0, 0, 100);
    for (int i = 0; i < 12; i++) step(4'h1, 100, 0, 0, 0);
    step(4'h1, 100, 100, 0, 0);
    for (int i = 0; i < 3; i++) step(4'h1, 100, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(4'ha, 100, 0, 100, 0);
    for (int i = 0; i < 12; i++) step(4'ha, 100, 100, 0, 0);
    for (int i = 0; i < 600; i++) step(4'hf, 60, 40, 4, 1);
    for (int i = 0; i < 300; i++) step(4'hf, 50, 70, 10, 0);
    for (int i = 0; i < 200; i++) step(4'hf, 90, 20, 3, 2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of a 4-bit FIFO between N_REQ requesters. It tracks FIFO occupancy with an internal credit counter, so no write is granted when the FIFO is full. A flush mode stops all new grants until the consumer has drained the FIFO. It sits directly in front of the FIFO write side; the FIFO consumer's pop strobe feeds back into it.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- DATA_W, 4: data width; matches the FIFO data_in width.
- DEPTH, 8: FIFO capacity in entries; the credit counter saturates here.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N_REQ  requester i has a word to write.
- req_data  in  N_REQ*DATA_W  requester i data in slice [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot or zero; the word from requester i is accepted this cycle.
- rd_en  in  1  the FIFO consumer pops one entry this cycle.
- flush  in  1  request to stop granting and drain.
- wr_en  out  1  FIFO write strobe.
- wr_data  out  DATA_W  FIFO write data.
- grant_id  out  $clog2(N_REQ)  index of the granted requester; valid when wr_en=1.
- count  out  CNT_W  FIFO occupancy as tracked by the arbiter.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- flushing  out  1  state == FLUSH.

## Operation
- **State machine:** two states, RUN and FLUSH.
  - RUN -> FLUSH when flush=1.
  - FLUSH -> RUN when flush=0 and count==0.
  - Otherwise the state holds.
- **Grant enable:** grant_ok = (state==RUN) && !flush && !full && !rst.
- **Arbitration:** with grant_ok=1, search req_valid upward from pointer ptr with wrap-around. The first set bit is the winner w.
  - req_ready[w]=1 and all other bits are 0.
  - wr_en=1, wr_data=req_data[w], grant_id=w.
  - These outputs are combinational, so the accept and the FIFO write happen in the same cycle.
- **Pointer update:** on an accept, ptr <= (w+1) mod N_REQ. With no accept, ptr holds.
- **No grant:** when grant_ok=0 or no req_valid bit is set, req_ready=0, wr_en=0, wr_data=0 and grant_id=0.
- **Requester handshake:** req_valid must stay asserted with stable data until req_ready is seen. The arbiter never drops an accepted word.
- **Credit counter:**
  - wr_en only: count+1.
  - Effective pop only: count-1.
  - Both, or neither: count unchanged.
  - Effective pop = rd_en && count != 0. rd_en while count==0 is ignored; count never underflows.
- **Overflow safety:** count never exceeds DEPTH, because no grant is issued while full.
- **Full with simultaneous pop:** when count==DEPTH and rd_en=1 in the same cycle, no grant is issued. There is no same-cycle bypass.

## Timing
- **Reset:** rst=1 at an edge sets state=RUN, ptr=0, count=0.
  - While rst is high: req_ready=0, wr_en=0, wr_data=0, grant_id=0, full=0, empty=1, flushing=0.
  - Reset mid-transfer discards the tracked occupancy. The FIFO itself must be reset by the same rst.
- **Accept latency:** 0 cycles from req_valid to req_ready/wr_en. The new count is visible 1 cycle later.
- **Full/empty:** derived from the registered count, so they change on the edge after the event that caused them.
- **Flush entry:** flush suppresses grants in the same cycle it is high. flushing rises on the next edge.
- **Flush exit:** flushing falls on the edge where count==0 and flush==0 are both sampled. Grants resume in the following cycle.
- **Fairness:** with all N_REQ requesters continuously valid and space available, each is granted exactly once in every N_REQ consecutive grants.

## Structure
- **Shared package** (fifo_arb_pkg): state encoding constants ST_RUN=1'b0 and ST_FLUSH=1'b1, and the default DATA_W/DEPTH values shared with the FIFO.
- **Sub-module** (rr_pick): a combinational rotating-priority picker.
  - Inputs: req vector and base pointer.
  - Outputs: one-hot grant and its binary index.
  - Instantiated once in fifo_wr_arbiter.
- **Top level:** the FSM, ptr register, credit counter and output muxing live in fifo_wr_arbiter.

## Test plan
- **Reset:** assert rst for 3 cycles with req_valid=4'b1111 -> req_ready=0, wr_en=0, count=0, empty=1 throughout; the first grant after release goes to requester 0.
- **Round-robin:** hold req_valid=4'b1111 with data 4'h1/4'h2/4'h3/4'h4 and rd_en=1 every cycle -> grant_id sequence 0,1,2,3,0,...; wr_data 1,2,3,4,1,...; count stays at 1 after the first cycle.
- **Full:** rd_en=0 and req_valid=4'b0001 for 10 cycles -> exactly 8 writes; full=1 from cycle 9 and req_ready[0]=0 afterwards. One rd_en pulse -> count=7, then one more grant brings count back to 8.
- **Simultaneous and underflow:** count=3, one cycle with a grant and rd_en together -> count stays 3. With count=0, pulse rd_en -> count stays 0 and empty stays 1.
- **Flush:** count=5, pulse flush for 1 cycle with req_valid=4'b1010 -> no grants; flushing=1. Five rd_en pulses -> count=0, flushing=0 on the next edge, and the next grant goes to requester 1 (ptr=0).
- **Reset mid-flush:** assert rst while flushing=1 and count=4 -> state=RUN, count=0, flushing=0, ptr=0 on that edge.
